// File: rtl/c3lib_rst_seq_gen.sv
// Reset sequencer: asserts NUM_OUTS domain resets asynchronously, releases them in order.
// Latency: out[k] releases (k+1)*STEP_CYCLES clk after the sync chain qualifies rst_n.
// Backpressure: none; sw_rst_req/sw_rst_ack level handshake holds resets asserted.
// Optional macro RST_SEQ_SCAN_BYPASS_EN adds scan_mode/scan_rst_n output override.
module c3lib_rst_seq_gen #(
   parameter int SYNC_STAGES = 3,
   parameter int NUM_OUTS    = 4,
   parameter int STEP_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sw_rst_req,
`ifdef RST_SEQ_SCAN_BYPASS_EN
   input  logic                scan_mode,
   input  logic                scan_rst_n,
`endif
   output logic [NUM_OUTS-1:0] rst_out_n,
   output logic                rst_done,
   output logic                sw_rst_ack
);

   // The FSM state register acts as the last synchronizer stage: it leaves
   // HOLD on the same edge the full SYNC_STAGES-deep chain would report ok.
   localparam int CHAIN = SYNC_STAGES - 1;
   localparam int CW    = $clog2(STEP_CYCLES + 1);
   localparam int IW    = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_DONE    = 2'd2,
      ST_SW_HOLD = 2'd3
   } state_t;

   logic [CHAIN-1:0]    sync_q;
   logic                sync_ok;
   state_t              state_q, state_nxt;
   logic [CW-1:0]       cnt_q, cnt_nxt;
   logic [IW-1:0]       idx_q, idx_nxt;
   logic [NUM_OUTS-1:0] out_q, out_nxt;
   logic                done_q, done_nxt;
   logic                ack_q, ack_nxt;

   assign sync_ok = sync_q[CHAIN-1];

   // Shift constant 1 through the release synchronizer; cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= 1'b1;
         for (int i = 1; i < CHAIN; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // State, counter, index and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         idx_q   <= idx_nxt;
         out_q   <= out_nxt;
         done_q  <= done_nxt;
         ack_q   <= ack_nxt;
      end
   end

   // Next-state and next-output logic for the release sequence and sw handshake.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      idx_nxt   = idx_q;
      out_nxt   = out_q;
      done_nxt  = done_q;
      ack_nxt   = ack_q;
      case (state_q)
         ST_HOLD: begin
            out_nxt  = '0;
            done_nxt = 1'b0;
            if (sync_ok) begin
               cnt_nxt = '0;
               idx_nxt = '0;
               if (sw_rst_req) begin
                  state_nxt = ST_SW_HOLD;
                  ack_nxt   = 1'b1;
               end else begin
                  state_nxt = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            if (sw_rst_req) begin
               // Abort: re-assert everything already released.
               state_nxt = ST_SW_HOLD;
               out_nxt   = '0;
               done_nxt  = 1'b0;
               cnt_nxt   = '0;
               idx_nxt   = '0;
               ack_nxt   = 1'b1;
            end else if (cnt_q == CW'(STEP_CYCLES - 1)) begin
               // This edge brings the count to STEP_CYCLES: release one bit.
               out_nxt = out_q | (NUM_OUTS'(1) << idx_q);
               cnt_nxt = '0;
               if (idx_q == IW'(NUM_OUTS - 1)) begin
                  idx_nxt   = '0;
                  done_nxt  = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  idx_nxt = idx_q + IW'(1);
               end
            end else begin
               cnt_nxt = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (sw_rst_req) begin
               state_nxt = ST_SW_HOLD;
               out_nxt   = '0;
               done_nxt  = 1'b0;
               cnt_nxt   = '0;
               idx_nxt   = '0;
               ack_nxt   = 1'b1;
            end
         end
         ST_SW_HOLD: begin
            out_nxt  = '0;
            done_nxt = 1'b0;
            if (!sw_rst_req) begin
               state_nxt = ST_RELEASE;
               ack_nxt   = 1'b0;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_HOLD;
            out_nxt   = '0;
            done_nxt  = 1'b0;
            ack_nxt   = 1'b0;
            cnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   assign sw_rst_ack = ack_q;

`ifdef RST_SEQ_SCAN_BYPASS_EN
   // Scan override is purely combinational so test controls reset directly.
   assign rst_out_n = scan_mode ? {NUM_OUTS{scan_rst_n}} : out_q;
   assign rst_done  = scan_mode ? scan_rst_n : done_q;
`else
   assign rst_out_n = out_q;
   assign rst_done  = done_q;
`endif

endmodule

// File: tb/tb_c3lib_rst_seq_gen.sv
// Directed bench for c3lib_rst_seq_gen: default instance plus a minimal-parameter corner instance.
module tb_c3lib_rst_seq_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sw_rst_req = 1'b0;
   logic       sw_c = 1'b0;
   logic [3:0] rst_out_n;
   logic       rst_done;
   logic       sw_rst_ack;
   logic [0:0] c_out_n;
   logic       c_done;
   logic       c_ack;

   int cmp_cnt = 0;
   int mis_cnt = 0;
   int edge_n = 0;

   c3lib_rst_seq_gen #(.SYNC_STAGES(3), .NUM_OUTS(4), .STEP_CYCLES(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_rst_req (sw_rst_req),
`ifdef RST_SEQ_SCAN_BYPASS_EN
      .scan_mode  (1'b0),
      .scan_rst_n (1'b0),
`endif
      .rst_out_n  (rst_out_n),
      .rst_done   (rst_done),
      .sw_rst_ack (sw_rst_ack)
   );

   c3lib_rst_seq_gen #(.SYNC_STAGES(2), .NUM_OUTS(1), .STEP_CYCLES(1)) dut_c (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_rst_req (sw_c),
`ifdef RST_SEQ_SCAN_BYPASS_EN
      .scan_mode  (1'b0),
      .scan_rst_n (1'b0),
`endif
      .rst_out_n  (c_out_n),
      .rst_done   (c_done),
      .sw_rst_ack (c_ack)
   );

   always #5 clk = ~clk;

   // Edge 1 is the first posedge after rst_n rises.
   always @(posedge clk) begin
      if (!rst_n) edge_n = 0;
      else        edge_n = edge_n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         mis_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the negedge following posedge n (bounded).
   task automatic step_to(input int n);
      int guard;
      guard = 0;
      while (edge_n < n && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (edge_n != n) begin
         cmp_cnt++;
         mis_cnt++;
         $display("FAIL step_to edge=%0d wanted=%0d", edge_n, n);
      end
   endtask

   initial begin
      // Reset values while rst_n is low.
      repeat (2) @(negedge clk);
      chk("rst_out_n_in_reset", 32'(rst_out_n), 32'h0);
      chk("rst_done_in_reset", 32'(rst_done), 32'h0);
      chk("ack_in_reset", 32'(sw_rst_ack), 32'h0);
      chk("corner_out_in_reset", 32'(c_out_n), 32'h0);
      rst_n = 1'b1;

      // Corner instance: SYNC=2, NUM=1, STEP=1 -> release at edge 3.
      step_to(2);
      chk("corner_out_e2", 32'(c_out_n), 32'h0);
      chk("corner_done_e2", 32'(c_done), 32'h0);
      step_to(3);
      chk("corner_out_e3", 32'(c_out_n), 32'h1);
      chk("corner_done_e3", 32'(c_done), 32'h1);

      // Power-on sequence: 11, 19, 27, 35.
      step_to(10); chk("po_e10", 32'(rst_out_n), 32'h0);
      step_to(11); chk("po_e11", 32'(rst_out_n), 32'h1);
      step_to(18); chk("po_e18", 32'(rst_out_n), 32'h1);
      step_to(19); chk("po_e19", 32'(rst_out_n), 32'h3);
      step_to(26); chk("po_e26", 32'(rst_out_n), 32'h3);
      step_to(27); chk("po_e27", 32'(rst_out_n), 32'h7);
      step_to(34); chk("po_e34", 32'(rst_out_n), 32'h7);
      chk("po_done_e34", 32'(rst_done), 32'h0);
      step_to(35); chk("po_e35", 32'(rst_out_n), 32'hF);
      chk("po_done_e35", 32'(rst_done), 32'h1);
      chk("po_ack_e35", 32'(sw_rst_ack), 32'h0);

      // Software reset from DONE: sampled 1 at edge 50, sampled 0 at edge 60.
      step_to(49); sw_rst_req = 1'b1;
      chk("sw_pre_e49", 32'(rst_out_n), 32'hF);
      step_to(50);
      chk("sw_out_e50", 32'(rst_out_n), 32'h0);
      chk("sw_done_e50", 32'(rst_done), 32'h0);
      chk("sw_ack_e50", 32'(sw_rst_ack), 32'h1);
      step_to(59); sw_rst_req = 1'b0;
      chk("sw_ack_e59", 32'(sw_rst_ack), 32'h1);
      step_to(60);
      chk("sw_ack_e60", 32'(sw_rst_ack), 32'h0);
      chk("sw_out_e60", 32'(rst_out_n), 32'h0);
      step_to(67); chk("sw_e67", 32'(rst_out_n), 32'h0);
      step_to(68); chk("sw_e68", 32'(rst_out_n), 32'h1);
      step_to(76); chk("sw_e76", 32'(rst_out_n), 32'h3);
      step_to(84); chk("sw_e84", 32'(rst_out_n), 32'h7);
      step_to(91); chk("sw_done_e91", 32'(rst_done), 32'h0);
      step_to(92); chk("sw_e92", 32'(rst_out_n), 32'hF);
      chk("sw_done_e92", 32'(rst_done), 32'h1);

      // Async reset between edges 20 and 21 of a fresh sequence.
      rst_n = 1'b0;
      #1;
      chk("arst_out_done", 32'(rst_out_n), 32'h0);
      chk("arst_done_done", 32'(rst_done), 32'h0);
      chk("arst_corner_out", 32'(c_out_n), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step_to(20); chk("arst_pre_e20", 32'(rst_out_n), 32'h3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mid_out", 32'(rst_out_n), 32'h0);
      chk("arst_mid_ack", 32'(sw_rst_ack), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      step_to(10); chk("re_e10", 32'(rst_out_n), 32'h0);
      step_to(11); chk("re_e11", 32'(rst_out_n), 32'h1);
      step_to(19); chk("re_e19", 32'(rst_out_n), 32'h3);

      // Abort mid-release: sampled 1 at edge 22, sampled 0 at edge 30.
      step_to(21); sw_rst_req = 1'b1;
      chk("ab_pre_e21", 32'(rst_out_n), 32'h3);
      step_to(22);
      chk("ab_out_e22", 32'(rst_out_n), 32'h0);
      chk("ab_ack_e22", 32'(sw_rst_ack), 32'h1);
      step_to(27); chk("ab_hold_e27", 32'(rst_out_n), 32'h0);
      step_to(29); sw_rst_req = 1'b0;
      step_to(30); chk("ab_ack_e30", 32'(sw_rst_ack), 32'h0);
      step_to(37); chk("ab_e37", 32'(rst_out_n), 32'h0);
      step_to(38); chk("ab_e38", 32'(rst_out_n), 32'h1);
      step_to(46); chk("ab_e46", 32'(rst_out_n), 32'h3);
      step_to(62); chk("ab_e62", 32'(rst_out_n), 32'hF);
      chk("ab_done_e62", 32'(rst_done), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule

// File: doc/c3lib_rst_seq_gen.md
Name: c3lib_rst_seq_gen

Overview:
- Reset generator for c3lib flops that take an asynchronous active-low reset.
- Asserts a vector of domain resets asynchronously and releases them synchronously to clk, one at a time, in order: bit 0 first, then bit 1, and so on.
- Supports a synchronous software reset request/acknowledge handshake.
- Sits at the reset root of each clock domain in the AIB adapter; its outputs drive the rst_n pins of downstream dff primitives.

Parameters:
- SYNC_STAGES, 3, depth of the reset-release synchronizer chain. Legal range 2..5.
- NUM_OUTS, 4, number of sequenced reset outputs. Must be at least 1.
- STEP_CYCLES, 8, clk cycles between successive output releases. Must be at least 1. The counter width is clog2(STEP_CYCLES+1).

Ports:
- clk  input  1  block clock.
- rst_n  input  1  asynchronous active-low master reset.
- sw_rst_req  input  1  software reset request. Level-sensitive, synchronous to clk.
- rst_out_n  output  NUM_OUTS  sequenced active-low resets. Bit 0 is released first.
- rst_done  output  1  high once all rst_out_n bits are released.
- sw_rst_ack  output  1  high while a software reset is being held.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- While rst_n=0, the following hold immediately, without waiting for clk:
  - synchronizer chain = 0
  - rst_out_n = all 0
  - rst_done = 0
  - sw_rst_ack = 0
  - FSM = HOLD
  - counter = 0
- All outputs are registered. No combinational path runs from any input to any output, apart from the async reset.
- Synchronizer: a SYNC_STAGES-deep shift of constant 1. Its output sync_ok rises at the SYNC_STAGES-th posedge after rst_n rises. Call that edge S.
- FSM states: HOLD, RELEASE, DONE, SW_HOLD.
- HOLD:
  - Outputs are all asserted.
  - When sync_ok=1 and sw_rst_req=0, go to RELEASE with counter=0 and next index=0.
  - When sync_ok=1 and sw_rst_req=1, go to SW_HOLD.
- RELEASE:
  - The counter increments each cycle.
  - When the counter reaches STEP_CYCLES, set rst_out_n[index]=1, clear the counter and increment the index.
  - Timing: rst_out_n[k] rises at edge S+(k+1)*STEP_CYCLES.
  - When the last index is released, rst_done rises on the same edge and the FSM goes to DONE.
- DONE:
  - Outputs are stable: rst_out_n all 1, rst_done=1.
  - sw_rst_req sampled 1 at edge E: after E, rst_out_n=0, rst_done=0, sw_rst_ack=1, and the FSM goes to SW_HOLD.
- SW_HOLD:
  - Outputs remain asserted.
  - sw_rst_req sampled 0 at edge F: after F, sw_rst_ack=0 and the FSM goes to RELEASE with counter and index cleared.
  - rst_out_n[k] then rises at edge F+(k+1)*STEP_CYCLES.
- Software request arriving mid-sequence:
  - sw_rst_req=1 sampled in RELEASE aborts the sequence.
  - On that edge, all already-released bits re-assert, the counter and index clear, and the FSM goes to SW_HOLD.
- Reset mid-operation: rst_n low in any state forces the reset values immediately. The full sequence restarts from edge S after rst_n rises.
- rst_out_n bits are monotonic within one sequence: once a bit is released it stays high until a software request or rst_n assertion. Release order is never violated.
- sw_rst_req glitches shorter than one cycle that are not sampled have no effect.

Optional Feature:
- Macro RST_SEQ_SCAN_BYPASS_EN.
- Defined:
  - Adds input ports scan_mode (1 bit) and scan_rst_n (1 bit).
  - While scan_mode=1, every rst_out_n bit = scan_rst_n, combinationally, and rst_done = scan_rst_n.
  - The FSM continues to run internally.
  - While scan_mode=0, behaviour is as above.
- Undefined: these ports are absent and outputs always come from the FSM.

Test Plan:
Defaults SYNC_STAGES=3, NUM_OUTS=4, STEP_CYCLES=8 unless stated; edge 1 is the first posedge after rst_n rises.
- Power-on: rst_n released before edge 1, sw_rst_req=0 -> rst_out_n[0..3] rise at edges 11, 19, 27 and 35. rst_done rises at edge 35. All bits are 0 before edge 11.
- SW reset from DONE: sw_rst_req=1 at edge 50, dropped so it samples 0 at edge 60 -> after edge 50, rst_out_n=4'b0000, rst_done=0, sw_rst_ack=1. sw_rst_ack falls after edge 60. Bits release at edges 68, 76, 84 and 92.
- SW abort mid-release: sw_rst_req sampled 1 at edge 22 (rst_out_n=4'b0011) -> after edge 22, rst_out_n=4'b0000 and sw_rst_ack=1. Release sampled at edge 30 -> bit 0 rises at edge 38.
- Async reset mid-sequence: rst_n dropped between edges 20 and 21 -> rst_out_n=0 immediately, before the next edge. After rst_n rises, the sequence repeats with edge 11 timing relative to the new edge 1.
- Parameter corners: SYNC_STAGES=2, NUM_OUTS=1, STEP_CYCLES=1 -> rst_out_n[0] and rst_done rise at edge 3.
- With RST_SEQ_SCAN_BYPASS_EN defined: scan_mode=1 and scan_rst_n toggled 0/1 during HOLD -> all rst_out_n and rst_done follow scan_rst_n with zero cycle latency. With scan_mode=0, the output timing of the power-on scenario holds.
